ssd_attitude_scanner: RTL and testbench

- Parametrised, time-multiplexed successor to the two-digit attitude-glyph decoder.
- Accepts signed roll and pitch samples and classifies each with a programmable deadband.
- Renders a horizon glyph across NUM_DIGITS common-anode 7-segment digits by scanning one digit at a time.
- Adds overrange blinking and stale-data indication. Sits between the IMU angle pipeline and the board-level display pins.

---
 rtl/ssd_pkg.sv | 38 +++
 rtl/ssd_glyph_rom.sv | 38 +++
 rtl/ssd_attitude_scanner.sv | 151 +++++++++++++++
 tb/tb_ssd_attitude_scanner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared segment constants and attitude flag types for the scanner
package ssd_pkg;

    // Bit positions inside the {G,F,E,D,C,B,A} segment vector
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-low "all segments off" for a common-anode digit
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-high A+D+G, shown on every digit while data is stale
    localparam logic [6:0] STALE_GLYPH = 7'b100_1001;

    // Classified attitude: signs, deadband-zero flags and overrange
    typedef struct packed {
        logic s_r;
        logic s_p;
        logic z_r;
        logic z_p;
        logic ovr;
    } att_flags_t;

    // Level attitude: both axes zero, positive, in range
    localparam att_flags_t FLAGS_LEVEL = '{s_r: 1'b0, s_p: 1'b0, z_r: 1'b1, z_p: 1'b1, ovr: 1'b0};

    // Which glyph family a digit position uses
    typedef enum logic [1:0] {
        POS_LEFT  = 2'd0,
        POS_MID   = 2'd1,
        POS_RIGHT = 2'd2
    } pos_t;

endpackage

// File: rtl/ssd_glyph_rom.sv
// rtl/ssd_glyph_rom.sv - maps attitude flags and digit position to an active-high segment pattern
module ssd_glyph_rom
    import ssd_pkg::*;
(
    input  att_flags_t  flags,
    input  pos_t        pos,
    output logic [6:0]  glyph
);

    // Overrange only affects blinking, which the top level handles
    logic unused_ovr;
    assign unused_ovr = flags.ovr;

    // Horizon glyph: left digit leans on positive roll, right on negative roll
    always_comb begin
        glyph = 7'h00;
        glyph[SEG_G] = flags.z_r & flags.z_p;
        case (pos)
            POS_LEFT: begin
                glyph[SEG_A] = ~flags.s_r &  flags.s_p & ~flags.z_p;
                glyph[SEG_D] = ~flags.s_r & ~flags.s_p & ~flags.z_p;
                glyph[SEG_E] = ~flags.s_r & ~flags.s_p & ~flags.z_r;
                glyph[SEG_F] = ~flags.s_r &  flags.s_p & ~flags.z_r;
            end
            POS_RIGHT: begin
                glyph[SEG_A] =  flags.s_r &  flags.s_p & ~flags.z_p;
                glyph[SEG_B] =  flags.s_r &  flags.s_p & ~flags.z_r;
                glyph[SEG_C] =  flags.s_r & ~flags.s_p & ~flags.z_r;
                glyph[SEG_D] =  flags.s_r & ~flags.s_p & ~flags.z_p;
            end
            default: begin
                glyph[SEG_A] =  flags.s_p & ~flags.z_p;
                glyph[SEG_D] = ~flags.s_p & ~flags.z_p;
            end
        endcase
    end

endmodule

// File: rtl/ssd_attitude_scanner.sv
// rtl/ssd_attitude_scanner.sv - multiplexed 7-segment horizon display with overrange blink and stale flag
module ssd_attitude_scanner
    import ssd_pkg::*;
#(
    parameter int ANGLE_W    = 16,
    parameter int NUM_DIGITS = 4,
    parameter int DEADBAND   = 8,
    parameter int LIMIT      = 4096,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 5000000,
    parameter int TIMEOUT    = 10000000
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset,
    input  logic signed [ANGLE_W-1:0]   i_Roll,
    input  logic signed [ANGLE_W-1:0]   i_Pitch,
    input  logic                        i_Valid,
    output logic [6:0]                  o_Seg,
    output logic [NUM_DIGITS-1:0]       o_Dig,
    output logic                        o_Stale
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [TMO_W-1:0]   TMO_MAX    = TMO_W'(TIMEOUT);
    localparam logic [ANGLE_W:0]   DB_U       = (ANGLE_W + 1)'(DEADBAND);
    localparam logic [ANGLE_W:0]   LIM_U      = (ANGLE_W + 1)'(LIMIT);
    localparam logic [ANGLE_W:0]   ONE_U      = (ANGLE_W + 1)'(1);

    att_flags_t             flags_q, flags_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SCAN_W-1:0]      scan_q, scan_d;
    logic [BLINK_W-1:0]     blink_q, blink_d;
    logic                   phase_q, phase_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   stale_q, stale_d;
    logic [6:0]             seg_q, seg_d;
    logic [NUM_DIGITS-1:0]  dig_q, dig_d;

    logic [ANGLE_W:0]       roll_ext, pitch_ext, abs_roll, abs_pitch;
    pos_t                   pos;
    logic [6:0]             glyph;

    // Magnitudes carry one extra bit so the most negative sample does not wrap
    always_comb begin
        roll_ext  = {i_Roll[ANGLE_W-1], i_Roll};
        pitch_ext = {i_Pitch[ANGLE_W-1], i_Pitch};
        abs_roll  = roll_ext[ANGLE_W]  ? (~roll_ext + ONE_U)  : roll_ext;
        abs_pitch = pitch_ext[ANGLE_W] ? (~pitch_ext + ONE_U) : pitch_ext;
    end

    // Capture stage: classify a new sample, otherwise hold the last attitude
    always_comb begin
        flags_d = flags_q;
        if (i_Valid) begin
            flags_d.s_r = i_Roll[ANGLE_W-1];
            flags_d.s_p = i_Pitch[ANGLE_W-1];
            flags_d.z_r = (abs_roll <= DB_U);
            flags_d.z_p = (abs_pitch <= DB_U);
            flags_d.ovr = (abs_roll > LIM_U) || (abs_pitch > LIM_U);
        end
    end

    // Scan, blink and timeout counters; stale is sticky until a sample arrives
    always_comb begin
        scan_d  = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
        idx_d   = idx_q;
        if (scan_q == SCAN_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
        phase_d = (blink_q == BLINK_LAST) ? ~phase_q : phase_q;
        if (i_Valid) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        stale_d = ~i_Valid & (stale_q | (tmo_d == TMO_MAX));
    end

    // Glyph family follows the digit that will be driven next cycle
    always_comb begin
        if (idx_d == '0) begin
            pos = POS_LEFT;
        end else if (idx_d == IDX_LAST) begin
            pos = POS_RIGHT;
        end else begin
            pos = POS_MID;
        end
    end

    ssd_glyph_rom u_glyph_rom (
        .flags (flags_q),
        .pos   (pos),
        .glyph (glyph)
    );

    // Output stage: blank the first cycle of each slot, then drive the selected digit
    always_comb begin
        dig_d = '1;
        seg_d = SEG_BLANK;
        if (scan_d != '0) begin
            dig_d[idx_d] = 1'b0;
            if (stale_q) begin
                seg_d = ~STALE_GLYPH;
            end else if (flags_q.ovr && !phase_q) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = ~glyph;
            end
        end
    end

    // All state, including the registered outputs
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            flags_q <= FLAGS_LEVEL;
            idx_q   <= '0;
            scan_q  <= '0;
            blink_q <= '0;
            phase_q <= 1'b1;
            tmo_q   <= '0;
            stale_q <= 1'b1;
            seg_q   <= SEG_BLANK;
            dig_q   <= '1;
        end else begin
            flags_q <= flags_d;
            idx_q   <= idx_d;
            scan_q  <= scan_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            tmo_q   <= tmo_d;
            stale_q <= stale_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign o_Seg   = seg_q;
    assign o_Dig   = dig_q;
    assign o_Stale = stale_q;

endmodule

// File: tb/tb_ssd_attitude_scanner.sv
// tb/tb_ssd_attitude_scanner.sv - directed self-checking bench for ssd_attitude_scanner
module tb_ssd_attitude_scanner;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] roll;
    logic signed [15:0] pitch;
    logic               valid;
    logic [6:0]         seg;
    logic [3:0]         dig;
    logic               stale;

    int errors = 0;
    int checks = 0;

    ssd_attitude_scanner #(
        .ANGLE_W    (16),
        .NUM_DIGITS (4),
        .DEADBAND   (8),
        .LIMIT      (4096),
        .SCAN_DIV   (4),
        .BLINK_DIV  (16),
        .TIMEOUT    (50)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .i_Roll  (roll),
        .i_Pitch (pitch),
        .i_Valid (valid),
        .o_Seg   (seg),
        .o_Dig   (dig),
        .o_Stale (stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] r, input logic signed [15:0] p);
        @(negedge clk);
        roll  = r;
        pitch = p;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_digit(input int d, output bit ok);
        logic [3:0] mask;
        mask = ~(4'b0001 << d);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dig == mask) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic show_digit(input int d, input logic [6:0] exp, input string tag);
        bit ok;
        wait_digit(d, ok);
        chk({tag, " enabled"}, ok, 1);
        if (ok) chk(tag, seg, exp);
    endtask

    task automatic watch(input int d, input int cycles, input logic [6:0] glyph,
                         output int n_glyph, output int n_blank, output int n_other);
        logic [3:0] mask;
        mask = ~(4'b0001 << d);
        n_glyph = 0;
        n_blank = 0;
        n_other = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (dig == mask) begin
                if (seg == glyph)       n_glyph++;
                else if (seg == 7'h7F)  n_blank++;
                else                    n_other++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int ng, nb, no;
        rst   = 1'b1;
        valid = 1'b0;
        roll  = '0;
        pitch = '0;
        repeat (3) @(negedge clk);
        chk("reset seg", seg, 7'h7F);
        chk("reset dig", dig, 4'hF);
        chk("reset stale", stale, 1);
        rst = 1'b0;

        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (dig != 4'hF) ok = 1'b1;
        end
        chk("first digit after reset", dig, 4'hE);
        chk("stale before sample", stale, 1);

        // level
        send(0, 0);
        chk("stale cleared", stale, 0);
        show_digit(0, 7'h3F, "level d0");
        show_digit(1, 7'h3F, "level d1");
        show_digit(2, 7'h3F, "level d2");
        show_digit(3, 7'h3F, "level d3");

        // two-cycle latency measured inside digit 1's slot
        wait_digit(3, ok);
        wait_digit(1, ok);
        chk("latency slot found", ok, 1);
        roll  = -100;
        pitch = 100;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("latency +1 old glyph", seg, 7'h3F);
        chk("latency +1 digit", dig, 4'hD);
        chk("latency stale", stale, 0);
        @(negedge clk);
        chk("latency +2 new glyph", seg, 7'h77);
        show_digit(3, 7'h73, "rneg pp d3");
        show_digit(0, 7'h7F, "rneg pp d0");
        show_digit(2, 7'h77, "rneg pp d2");

        // deadband
        send(5, -5);
        repeat (2) @(negedge clk);
        show_digit(0, 7'h3F, "db d0");
        show_digit(1, 7'h3F, "db d1");
        show_digit(3, 7'h3F, "db d3");
        send(8, -8);
        repeat (2) @(negedge clk);
        show_digit(0, 7'h3F, "db edge d0");
        send(9, 0);
        repeat (2) @(negedge clk);
        show_digit(0, 7'h6F, "roll9 d0");
        show_digit(2, 7'h7F, "roll9 d2");
        show_digit(3, 7'h7F, "roll9 d3");
        send(0, -9);
        repeat (2) @(negedge clk);
        show_digit(0, 7'h7E, "pitchm9 d0");
        show_digit(1, 7'h7E, "pitchm9 d1");
        show_digit(3, 7'h7F, "pitchm9 d3");

        // overrange blink, then recovery
        send(5000, 0);
        repeat (2) @(negedge clk);
        watch(0, 40, 7'h6F, ng, nb, no);
        chk("ovr glyph seen", ng > 0, 1);
        chk("ovr blank seen", nb > 0, 1);
        chk("ovr other", no, 0);
        send(100, 0);
        watch(0, 32, 7'h6F, ng, nb, no);
        chk("recover glyph seen", ng > 0, 1);
        chk("recover blanks", nb, 0);
        chk("recover other", no, 0);

        // most negative roll
        send(-32768, 0);
        repeat (2) @(negedge clk);
        watch(3, 40, 7'h7B, ng, nb, no);
        chk("minneg glyph seen", ng > 0, 1);
        chk("minneg blank seen", nb > 0, 1);
        chk("minneg other", no, 0);
        send(-32768, -32768);
        repeat (2) @(negedge clk);
        watch(3, 40, 7'h7C, ng, nb, no);
        chk("minneg both glyph seen", ng > 0, 1);
        chk("minneg both blank seen", nb > 0, 1);
        chk("minneg both other", no, 0);

        // stale: overrange attitude is still held, blinking must be suppressed
        repeat (60) @(negedge clk);
        chk("stale set", stale, 1);
        show_digit(0, 7'h36, "stale d0");
        show_digit(1, 7'h36, "stale d1");
        show_digit(2, 7'h36, "stale d2");
        show_digit(3, 7'h36, "stale d3");
        watch(1, 32, 7'h36, ng, nb, no);
        chk("stale no blink", nb, 0);
        chk("stale glyph seen", ng > 0, 1);

        // reset in the middle of a slot
        wait_digit(2, ok);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset dig", dig, 4'hF);
        chk("midreset seg", seg, 7'h7F);
        chk("midreset stale", stale, 1);
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (dig != 4'hF) ok = 1'b1;
        end
        chk("restart digit", dig, 4'hE);

        // a sample recovers from stale
        send(9, 0);
        chk("unstale", stale, 0);
        repeat (2) @(negedge clk);
        show_digit(0, 7'h6F, "unstale d0");
        show_digit(1, 7'h7F, "unstale d1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
